// File: rtl/button_conditioner.sv
// button_conditioner: synchronises, debounces and converts the three raw
// board buttons into clean single-cycle left/right/put request pulses.
// Optional build macro AUTO_REPEAT_EN: when defined, left/right auto-repeat
// while held; when undefined, they give one pulse per press, like put.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 10000000,
  parameter int CNT_W           = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       left,
  input  logic       right,
  input  logic       put,
  output logic       left_pulse,
  output logic       right_pulse,
  output logic       put_pulse,
  output logic [2:0] held
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // bit order everywhere: {put, right, left}
  logic [2:0]       raw;
  logic [2:0]       sync1;
  logic [2:0]       sync2;
  logic [2:0]       stable;
  logic [2:0]       stable_d;
  logic             both_d;
  logic [CNT_W-1:0] db_cnt [3];

  logic             both;
  logic [1:0]       fresh;
  logic             put_req;
  logic [1:0]       dir_req;

  assign raw  = {put, right, left};
  assign held = stable;

  // Two-flop synchroniser per button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Stability counter per button; any cycle matching the stable level restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i] <= '0;
          stable[i] <= ~stable[i];
        end else if (db_cnt[i] != CNT_MAX) begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Delayed copies for edge detection and for spotting the end of a left/right conflict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_d <= '0;
      both_d   <= 1'b0;
    end else begin
      stable_d <= stable;
      both_d   <= both;
    end
  end

  // A direction counts as freshly pressed on its own rise, or when the other
  // direction is released while it is still held.
  assign both     = stable[0] & stable[1];
  assign fresh[0] = stable[0] & ~both & (~stable_d[0] | both_d);
  assign fresh[1] = stable[1] & ~both & (~stable_d[1] | both_d);
  assign put_req  = stable[2] & ~stable_d[2];

`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RR_LOAD = CNT_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    REPEAT = 2'd2
  } dir_state_t;

  dir_state_t       state     [2];
  dir_state_t       state_nxt [2];
  logic [CNT_W-1:0] rep_cnt     [2];
  logic [CNT_W-1:0] rep_cnt_nxt [2];

  // Direction FSM state and repeat down-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        state[i]   <= IDLE;
        rep_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        state[i]   <= state_nxt[i];
        rep_cnt[i] <= rep_cnt_nxt[i];
      end
    end
  end

  // Direction FSM next state: press pulse, delayed first repeat, then periodic repeats.
  always_comb begin
    dir_req = '0;
    for (int i = 0; i < 2; i++) begin
      state_nxt[i]   = state[i];
      rep_cnt_nxt[i] = (rep_cnt[i] != '0) ? rep_cnt[i] - 1'b1 : rep_cnt[i];
      case (state[i])
        IDLE: begin
          if (fresh[i]) begin
            dir_req[i]     = 1'b1;
            rep_cnt_nxt[i] = RD_LOAD;
            state_nxt[i]   = WAIT;
          end
        end
        WAIT, REPEAT: begin
          if (!stable[i] || both) begin
            state_nxt[i] = IDLE;
          end else if (rep_cnt[i] == '0) begin
            dir_req[i]     = 1'b1;
            rep_cnt_nxt[i] = RR_LOAD;
            state_nxt[i]   = REPEAT;
          end
        end
        default: state_nxt[i] = IDLE;
      endcase
    end
  end
`else
  localparam int unused_repeat_params = REPEAT_DELAY ^ REPEAT_RATE;

  // Without auto-repeat a direction pulses once per fresh press.
  always_comb begin
    dir_req = fresh;
  end
`endif

  // Registered outputs; put wins over a direction, left over right, so at most one is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      put_pulse   <= 1'b0;
      left_pulse  <= 1'b0;
      right_pulse <= 1'b0;
    end else begin
      put_pulse   <= put_req;
      left_pulse  <= dir_req[0] & ~put_req;
      right_pulse <= dir_req[1] & ~put_req & ~dir_req[0];
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with DEBOUNCE=4, REPEAT_DELAY=20, REPEAT_RATE=8.
// Expected pulse events are queued per scenario and matched as pulses appear.
module tb_button_conditioner;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RR = 8;
`ifdef AUTO_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  localparam logic [2:0] K_L = 3'b001;
  localparam logic [2:0] K_R = 3'b010;
  localparam logic [2:0] K_P = 3'b100;

  logic       clk = 1'b0;
  logic       rst;
  logic       left, right, put;
  logic       left_pulse, right_pulse, put_pulse;
  logic [2:0] held;

  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR),
    .CNT_W          (25)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .left       (left),
    .right      (right),
    .put        (put),
    .left_pulse (left_pulse),
    .right_pulse(right_pulse),
    .put_pulse  (put_pulse),
    .held       (held)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [2:0] kind;
  } exp_t;

  exp_t       q[$];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  logic [2:0] obs_held;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] kind, input int c);
    exp_t e;
    e.cyc  = c;
    e.kind = kind;
    q.push_back(e);
  endtask

  // First pulse at 'first'; with repeat, more at first+RD, then every RR while
  // the stable level is still high in the cycle before (t <= fall).
  task automatic push_dir(input logic [2:0] kind, input int first, input int fall, input bit incl_first);
    if (incl_first) push(kind, first);
    if (REP) begin
      for (int t = first + RD; t <= fall; t += RR) push(kind, t);
    end
  endtask

  // Sample at the falling edge, match any pulse to the queue, advance one cycle.
  task automatic tick();
    logic [2:0] p;
    exp_t       e;
    @(negedge clk);
    p        = {put_pulse, right_pulse, left_pulse};
    obs_held = held;
    if (p != 3'b000) begin
      if (q.size() == 0) begin
        chk($sformatf("unexpected_pulse_at_%0d", cyc), {29'd0, p}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("pulse_kind", {29'd0, p}, {29'd0, e.kind});
        chk("pulse_cycle", cyc, e.cyc);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start();
    rst   = 1'b1;
    left  = 1'b0;
    right = 1'b0;
    put   = 1'b0;
    q.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_held", {29'd0, held}, 32'd0);
    chk("rst_pulses", {29'd0, put_pulse, right_pulse, left_pulse}, 32'd0);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic finish_scn(input string name);
    chk({name, "_missing_pulses"}, q.size(), 32'd0);
  endtask

  initial begin
    // clean left press, released after 10 cycles
    start();
    push_dir(K_L, 7, 16, 1'b1);
    for (int c = 0; c < 40; c++) begin
      if (c == 0)  left = 1'b1;
      if (c == 10) left = 1'b0;
      tick();
      if (c == 5)  chk("clean_held5",  {29'd0, obs_held}, 32'd0);
      if (c == 6)  chk("clean_held6",  {29'd0, obs_held}, 32'd1);
      if (c == 15) chk("clean_held15", {29'd0, obs_held}, 32'd1);
      if (c == 16) chk("clean_held16", {29'd0, obs_held}, 32'd0);
    end
    finish_scn("clean");

    // put bounces 1,0,1,0 then settles high at cycle 4
    start();
    push(K_P, 11);
    for (int c = 0; c < 45; c++) begin
      if (c <= 4)  put = (c % 2 == 0);
      if (c == 30) put = 1'b0;
      tick();
      if (c == 9)  chk("bounce_held9",  {29'd0, obs_held}, 32'd0);
      if (c == 10) chk("bounce_held10", {29'd0, obs_held}, 32'd4);
    end
    finish_scn("bounce");

    // right held for 60 cycles
    start();
    push_dir(K_R, 7, 66, 1'b1);
    for (int c = 0; c < 90; c++) begin
      if (c == 0)  right = 1'b1;
      if (c == 60) right = 1'b0;
      tick();
      if (c == 65) chk("repeat_held65", {29'd0, obs_held}, 32'd2);
      if (c == 66) chk("repeat_held66", {29'd0, obs_held}, 32'd0);
    end
    finish_scn("repeat");

    // left held, right joins at 10, left released at 40, right at 80
    start();
    push_dir(K_L, 7, 16, 1'b1);
    push_dir(K_R, 47, 86, 1'b1);
    for (int c = 0; c < 100; c++) begin
      if (c == 0)  left  = 1'b1;
      if (c == 10) right = 1'b1;
      if (c == 40) left  = 1'b0;
      if (c == 80) right = 1'b0;
      tick();
      if (c == 16) chk("conflict_held16", {29'd0, obs_held}, 32'd3);
      if (c == 46) chk("conflict_held46", {29'd0, obs_held}, 32'd2);
    end
    finish_scn("conflict");

    // put and left rise together; direction pulse dropped, repeats unaffected
    start();
    push(K_P, 7);
    push_dir(K_L, 7, 46, 1'b0);
    for (int c = 0; c < 60; c++) begin
      if (c == 0) begin
        put  = 1'b1;
        left = 1'b1;
      end
      if (c == 40) begin
        put  = 1'b0;
        left = 1'b0;
      end
      tick();
      if (c == 6) chk("prio_held6", {29'd0, obs_held}, 32'd5);
    end
    finish_scn("priority");

    // reset pulse mid-hold of put
    start();
    push(K_P, 15);
    for (int c = 0; c < 45; c++) begin
      if (c == 0)  put = 1'b1;
      if (c == 5)  rst = 1'b1;
      if (c == 8)  rst = 1'b0;
      if (c == 30) put = 1'b0;
      tick();
      if (c == 6)  chk("midrst_held6",  {29'd0, obs_held}, 32'd0);
      if (c == 7)  chk("midrst_held7",  {29'd0, obs_held}, 32'd0);
      if (c == 13) chk("midrst_held13", {29'd0, obs_held}, 32'd0);
      if (c == 14) chk("midrst_held14", {29'd0, obs_held}, 32'd4);
    end
    finish_scn("midreset");

    // left held for 60 cycles
    start();
    push_dir(K_L, 7, 66, 1'b1);
    for (int c = 0; c < 90; c++) begin
      if (c == 0)  left = 1'b1;
      if (c == 60) left = 1'b0;
      tick();
    end
    finish_scn("left_hold");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Upstream input stage of the score4 game. It feeds the game-state logic with clean single-cycle left/right/put pulses.
- Each raw board button is synchronised into the clk domain, debounced with a per-button stability counter, and converted to a one-clock press pulse.
- Left/right additionally auto-repeat while held, so the column cursor can sweep across the board.
- The block applies arbitration so the game logic never sees conflicting pulses in one cycle.

Parameters:
- DEBOUNCE_CYCLES, 500000, cycles a synced level must stay unchanged before it is accepted (10 ms at 50 MHz); minimum 2.
- REPEAT_DELAY, 25000000, cycles from the initial direction pulse to the first auto-repeat pulse.
- REPEAT_RATE, 10000000, cycles between subsequent auto-repeat pulses.
- CNT_W, 25, counter width; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- left  input  1  raw left button, active-high, asynchronous to clk
- right  input  1  raw right button, active-high, asynchronous to clk
- put  input  1  raw put button, active-high, asynchronous to clk
- left_pulse  output  1  one-cycle move-left request
- right_pulse  output  1  one-cycle move-right request
- put_pulse  output  1  one-cycle drop-token request
- held  output  3  debounced stable levels {put, right, left}, for status LEDs

Behaviour:
- Reset: asynchronous, active-high. While rst is high, all synchroniser flops, counters, stable levels and FSMs clear; left_pulse = right_pulse = put_pulse = 0; held = 3'b000. A button held through reset release must pass full debounce before any pulse.
- Synchroniser: 2-FF per button; 2 cycles of latency.
- Debounce, per button:
  - Counter increments while the synced level differs from the stable level, and clears on any cycle where they match (a bounce restarts the count).
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, stable toggles and the counter clears.
- Pulse generation: a registered rising edge of stable gives a 1-cycle pulse in the cycle after stable rises. Total latency from a clean raw edge to the pulse is DEBOUNCE_CYCLES+3 clocks. A stable fall generates nothing.
- Direction FSM, one each for left and right:
  - IDLE: on stable rise, emit pulse, load repeat counter, go to WAIT.
  - WAIT: after REPEAT_DELAY cycles, emit pulse, reload, go to REPEAT.
  - REPEAT: emit a pulse every REPEAT_RATE cycles.
  - On stable fall from WAIT or REPEAT, return to IDLE immediately; no pulse is emitted on the release cycle.
- put: press-only. It never repeats; exactly one pulse per debounced press.
- Arbitration, applied to the registered outputs:
  - If left and right stable are both high, both direction FSMs are forced to IDLE and no direction pulses are emitted until one is released. The remaining held one then behaves as a fresh press, after a full REPEAT_DELAY.
  - If put_pulse and a direction pulse coincide, put_pulse is emitted and the direction pulse is dropped, not deferred.
  - At most one output pulse is high in any cycle.
- Counters saturate; they never wrap.
- Outputs are registered, with no combinational path from raw inputs.

Optional Feature:
- Macro AUTO_REPEAT_EN.
- Defined: the WAIT/REPEAT behaviour above is compiled in.
- Undefined: repeat counters and the WAIT/REPEAT states are not generated. Left/right behave exactly like put: one pulse per debounced press, regardless of hold time. REPEAT_DELAY and REPEAT_RATE are ignored.

Test Plan:
- Params 4/20/8, AUTO_REPEAT_EN defined.
- Clean press: raise left at cycle 0 and hold 10 cycles → left_pulse high only at cycle 7; held[0] = 1 from cycle 6; no other pulse.
- Bounce: put toggles 1,0,1,0 at 1-cycle spacing, then stays high → exactly one put_pulse, 7 cycles after the final rising edge; none during the bounce.
- Auto-repeat: hold right 60 cycles → right_pulse at cycles 7, 27, 35, 43, 51, 59; none after release.
- Conflict: hold left, then press right 10 cycles later → left pulses until right becomes stable, then none while both are held. Release left → right_pulse 1 cycle after left stable falls, then the first repeat 20 cycles later.
- Priority: put and left rise on the same cycle → only put_pulse at cycle 7; left's first repeat still at cycle 27.
- Reset mid-hold: hold put, assert rst for 3 cycles at cycle 5, keep put high → all outputs 0 during reset; put_pulse 7 cycles after rst deasserts. With AUTO_REPEAT_EN undefined, holding left 60 cycles gives a single left_pulse at cycle 7.
